// File: rtl/dragon_length_ctrl_pkg.sv
// dragon_length_ctrl_pkg: shared game-phase encodings, defaults and segment layout
package dragon_length_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SPAWN = 2'd1, S_PLAY = 2'd2, S_DEAD = 2'd3} state_t;
  localparam int MOVE_PERIOD_DEF = 10;
  localparam int MAX_LEN_DEF = 7;
  typedef struct packed {
    logic [1:0] orient;
    logic [7:0] pos;
  } segment_t;
endpackage

// File: rtl/dragon_length_ctrl_frame_ticker.sv
// dragon_length_ctrl_frame_ticker: vsync edge detect and wrapping movement counter
module dragon_length_ctrl_frame_ticker #(
  parameter int MOVE_PERIOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_vsync,
  input  logic       i_clr,
  output logic       o_frame_tick,
  output logic [5:0] o_count,
  output logic       o_move_tick
);
  logic       r_vsync_q;
  logic [5:0] r_count;
  logic       r_move_tick;
  logic       w_wrap;
  assign o_frame_tick = i_vsync & ~r_vsync_q;
  assign w_wrap = r_count == 6'(MOVE_PERIOD);
  assign o_count = r_count;
  assign o_move_tick = r_move_tick;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_vsync_q   <= 1'b0;
      r_count     <= '0;
      r_move_tick <= 1'b0;
    end else begin
      r_vsync_q   <= i_vsync;
      r_move_tick <= ~i_clr & o_frame_tick & w_wrap;
      if (i_clr) r_count <= '0;
      else if (o_frame_tick) r_count <= w_wrap ? '0 : r_count + 6'd1;
    end
endmodule

// File: rtl/dragon_length_ctrl.sv
// dragon_length_ctrl: game-phase FSM turning eat/damage requests into per-frame heal/hit pulses
module dragon_length_ctrl import dragon_length_ctrl_pkg::*; #(
  parameter int MOVE_PERIOD   = MOVE_PERIOD_DEF,
  parameter int MAX_LEN       = MAX_LEN_DEF,
  parameter int START_LEN     = 3,
  parameter int INVULN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       eat_req,
  input  logic       damage_req,
  output logic       heal,
  output logic       hit,
  output logic [5:0] movementCounter,
  output logic       move_tick,
  output logic [2:0] length,
  output logic       invuln,
  output logic       game_over,
  output logic [1:0] state
);
  state_t     r_state;
  logic [2:0] r_len;
  logic [5:0] r_inv;
  logic       r_pend_heal, r_pend_hit, r_heal, r_hit;
  logic       w_frame, w_play, w_ph, w_pt, w_die, w_clr;
  // requests arriving on the frame_tick cycle itself are served by that frame
  assign w_play = r_state == S_PLAY;
  assign w_ph = r_pend_heal | (w_play & eat_req);
  assign w_pt = r_pend_hit | (w_play & damage_req & (r_inv == 6'd0));
  assign w_die = w_frame & w_play & w_pt & (r_len == 3'd1);
  assign w_clr = start | w_die | ~(w_play | (r_state == S_SPAWN));
  dragon_length_ctrl_frame_ticker #(.MOVE_PERIOD(MOVE_PERIOD)) u_ticker (
    .clk(clk), .reset(reset), .i_vsync(vsync), .i_clr(w_clr),
    .o_frame_tick(w_frame), .o_count(movementCounter), .o_move_tick(move_tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_inv       <= '0;
      r_pend_heal <= 1'b0;
      r_pend_hit  <= 1'b0;
      r_heal      <= 1'b0;
      r_hit       <= 1'b0;
    end else if (start) begin
      r_state     <= S_SPAWN;
      r_len       <= '0;
      r_inv       <= '0;
      r_pend_heal <= 1'b0;
      r_pend_hit  <= 1'b0;
      r_heal      <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      r_heal      <= 1'b0;
      r_hit       <= 1'b0;
      r_pend_heal <= w_ph;
      r_pend_hit  <= w_pt;
      if (w_frame && r_inv != 6'd0) r_inv <= r_inv - 6'd1;
      if (w_frame && r_state == S_SPAWN) begin
        r_heal <= 1'b1;
        r_len  <= r_len + 3'd1;
        if (r_len + 3'd1 == 3'(START_LEN)) r_state <= S_PLAY;
      end
      if (w_frame && w_play) begin
        if (w_pt) begin
          r_hit      <= 1'b1;
          r_len      <= r_len - {2'b0, r_len != 3'd0};
          r_pend_hit <= 1'b0;
          r_inv      <= 6'(INVULN_FRAMES);
          if (r_len == 3'd1) begin
            r_state     <= S_DEAD;
            r_pend_heal <= 1'b0;
          end
        end else if (w_ph) begin
          r_pend_heal <= 1'b0;
          if (r_len < 3'(MAX_LEN)) begin
            r_heal <= 1'b1;
            r_len  <= r_len + 3'd1;
          end
        end
      end
    end
  assign heal = r_heal;
  assign hit = r_hit;
  assign length = r_len;
  assign invuln = r_inv != 6'd0;
  assign game_over = r_state == S_DEAD;
  assign state = r_state;
endmodule

// File: doc/dragon_length_ctrl.md
Name: dragon_length_ctrl

Overview:
- Sequencer for the dragon body segment queue. Owns the frame-rate movement counter and the game-phase FSM.
- Turns asynchronous eat/damage requests into at most one registered heal or hit pulse per frame, and tracks body length against those pulses.
- Sits between the collision logic and the body-segment block; drives that block's heal, hit and movementCounter inputs.

Parameters:
MOVE_PERIOD, 10, frames per movement step; counter wraps after reaching this value (1..63)
MAX_LEN, 7, maximum body segments (1..7)
START_LEN, 3, segments grown during spawn (1..MAX_LEN)
INVULN_FRAMES, 30, frames after a hit during which damage is ignored (0..63)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
vsync  input  1  video vsync level; rising edge marks a frame
start  input  1  one-cycle pulse: begin/restart game
eat_req  input  1  one-cycle pulse: dragon ate, request grow
damage_req  input  1  one-cycle pulse: dragon damaged, request shrink
heal  output  1  one-cycle grow pulse to body block
hit  output  1  one-cycle shrink pulse to body block
movementCounter  output  6  frame counter 0..MOVE_PERIOD
move_tick  output  1  one-cycle pulse when movementCounter wraps to 0
length  output  3  current segment count 0..MAX_LEN
invuln  output  1  high while invulnerability window active
game_over  output  1  high in DEAD state
state  output  2  FSM state: IDLE=0, SPAWN=1, PLAY=2, DEAD=3

Behaviour:
- Reset is asynchronous and active-high. It forces every output and internal register to 0: state=IDLE, movementCounter=0, length=0, heal=hit=move_tick=invuln=game_over=0, pending flags and invulnerability counter cleared. The same applies when reset asserts mid-operation.
- frame_tick: vsync is registered into vsync_q. frame_tick = vsync & ~vsync_q, a single cycle per vsync rising edge. Held vsync high produces no further ticks.
- movementCounter: advances only on frame_tick, and only in SPAWN/PLAY. Sequence 0,1,..,MOVE_PERIOD, then 0. move_tick is registered and asserts the cycle after the frame_tick that wraps the counter to 0. In IDLE/DEAD the counter is held at 0.
- Request capture: eat_req sets pend_heal and damage_req sets pend_hit in any cycle, in state PLAY only. Requests in other states are dropped. Both may be set in the same cycle. damage_req while invuln=1 is dropped.
- Issue: pulses are registered, asserted the cycle after frame_tick, at most one of heal/hit per frame.
  - PLAY with pend_hit: hit=1, length-1, pend_hit cleared. Hit has priority; pend_heal is retained for the next frame.
  - PLAY with only pend_heal: if length<MAX_LEN then heal=1, length+1. If length==MAX_LEN, no pulse and length unchanged. pend_heal is cleared in both cases.
  - SPAWN: heal=1 and length+1 on each frame until length==START_LEN, then go to PLAY in the same cycle as the last heal.
- Invulnerability: each hit loads INVULN_FRAMES into a down-counter, decremented on frame_tick. invuln = (counter!=0). With INVULN_FRAMES=0 there is no window.
- FSM:
  - IDLE --start--> SPAWN
  - SPAWN --length reaches START_LEN--> PLAY
  - PLAY --hit that takes length to 0--> DEAD. game_over=1 from the cycle after that hit.
  - DEAD --start--> SPAWN, with length=0, pending flags cleared, invuln cleared, counter=0.
  - start in SPAWN/PLAY restarts: length=0, pending flags cleared, invuln cleared, counter=0, state=SPAWN. The body block must also be reset externally; this block issues no hit pulses for a restart.
- Same-cycle start and frame_tick: start takes effect and the frame_tick issues nothing.
- Width rules: length never wraps; it saturates at 0 and MAX_LEN. Counters are 6-bit unsigned.

Decomposition:
- Shared game package holds:
  - FSM state encodings (IDLE/SPAWN/PLAY/DEAD)
  - MOVE_PERIOD and MAX_LEN defaults
  - the 10-bit segment layout: [9:8] orientation, [7:0] position
- One natural sub-module, frame_ticker: vsync edge detect plus the movementCounter/move_tick generator, reusable by other sprite controllers.

Test Plan:
- Reset then start, 3 vsync edges -> heal pulses 1 cycle after each frame_tick; length 1,2,3; state=PLAY after third heal; no hit.
- PLAY, 22 vsync edges -> movementCounter 0..10,0..10; move_tick exactly twice, each 1 cycle after the wrap-to-0 frame_tick.
- PLAY length=3, eat_req and damage_req same cycle, 2 frames -> frame1 hit (length=2, invuln=1), frame2 heal (length=3).
- Hit at length=3 then damage_req on each of the next 30 frames -> all ignored; after frame 30 invuln=0, next damage_req -> hit, length=2.
- length=7 plus eat_req -> no heal pulse, length stays 7. length=1 plus damage_req -> hit, length=0, game_over=1, state=DEAD. eat_req in DEAD -> ignored.
- Assert reset mid-SPAWN at length=2 -> all outputs 0 immediately (asynchronous). Then start -> normal 3-frame spawn.
